// File: rtl/vga_text_pkg.sv
// Shared definitions for the text-mode video path: control codes, writer
// states and default screen geometry.
package vga_text_pkg;

  localparam int          DEF_COLS  = 80;
  localparam int          DEF_ROWS  = 25;
  localparam logic [7:0]  DEF_BLANK = 8'h20;

  localparam logic [7:0]  CC_CR = 8'h0D;
  localparam logic [7:0]  CC_LF = 8'h0A;
  localparam logic [7:0]  CC_BS = 8'h08;
  localparam logic [7:0]  CC_FF = 8'h0C;

  typedef enum logic [1:0] {
    CLR_ALL,
    IDLE,
    CLR_ROW
  } state_t;

endpackage

// File: rtl/vga_console_writer.sv
// Terminal-style byte-stream writer feeding the vga_text video RAM write port,
// including clear-screen and clear-row fills.
module vga_console_writer
  import vga_text_pkg::*;
#(
  parameter int         COLS  = DEF_COLS,
  parameter int         ROWS  = DEF_ROWS,
  parameter logic [7:0] BLANK = DEF_BLANK
) (
  input  logic        vclk,
  input  logic        rst_n,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [11:0] vram_addr,
  output logic [7:0]  vram_data,
  output logic        vram_we,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row
);

  localparam logic [11:0] COLS12   = 12'(COLS);
  localparam logic [11:0] TOTAL12  = 12'(COLS * ROWS);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

  state_t      state;
  logic [11:0] fill_cnt;
  logic [11:0] row_base;
  logic [6:0]  col;
  logic [4:0]  row;

  logic [4:0]  next_row;
  logic [11:0] next_base;
  logic [11:0] cur_addr;

  // Row advance wraps to the top of the screen; the base tracks row*COLS
  // by accumulation so no multiplier is needed.
  assign next_row  = (row == LAST_ROW) ? 5'd0  : row + 5'd1;
  assign next_base = (row == LAST_ROW) ? 12'd0 : row_base + COLS12;
  assign cur_addr  = row_base + {5'd0, col};

  assign char_ready = (state == IDLE);
  assign cur_col    = col;
  assign cur_row    = row;

  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLR_ALL;
      fill_cnt  <= '0;
      row_base  <= '0;
      col       <= '0;
      row       <= '0;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_data <= BLANK;
    end else begin
      // NOTE: the default-low strobe is overridden below by a later
      // non-blocking assignment in the same edge, giving single-cycle pulses.
      vram_we <= 1'b0;
      case (state)
        CLR_ALL: begin
          if (fill_cnt == TOTAL12) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
          end else begin
            vram_we   <= 1'b1;
            vram_addr <= fill_cnt;
            vram_data <= BLANK;
            fill_cnt  <= fill_cnt + 12'd1;
          end
        end

        CLR_ROW: begin
          if (fill_cnt == COLS12) begin
            state <= IDLE;
          end else begin
            vram_we   <= 1'b1;
            vram_addr <= row_base + fill_cnt;
            vram_data <= BLANK;
            fill_cnt  <= fill_cnt + 12'd1;
          end
        end

        IDLE: begin
          if (char_valid) begin
            case (char_in)
              CC_CR: col <= '0;

              // LF has no character write, so the first blank is issued now.
              CC_LF: begin
                row       <= next_row;
                row_base  <= next_base;
                state     <= CLR_ROW;
                vram_we   <= 1'b1;
                vram_addr <= next_base;
                vram_data <= BLANK;
                fill_cnt  <= 12'd1;
              end

              CC_BS: begin
                if (col != 7'd0) begin
                  col       <= col - 7'd1;
                  vram_we   <= 1'b1;
                  vram_addr <= cur_addr - 12'd1;
                  vram_data <= BLANK;
                end
              end

              CC_FF: begin
                state    <= CLR_ALL;
                fill_cnt <= '0;
              end

              default: begin
                vram_we   <= 1'b1;
                vram_addr <= cur_addr;
                vram_data <= char_in;
                if (col == LAST_COL) begin
                  col      <= '0;
                  row      <= next_row;
                  row_base <= next_base;
                  state    <= CLR_ROW;
                  fill_cnt <= '0;
                end else begin
                  col <= col + 7'd1;
                end
              end
            endcase
          end
        end

        default: begin
          state    <= CLR_ALL;
          fill_cnt <= '0;
        end
      endcase
    end
  end

endmodule
